// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_receiver
// Asynchronous serial receiver with 16x (OSR) oversampling. It deserialises
// 5..9 data bits, LSB first, with optional even/odd parity and one stop bit.
// Each completed frame is placed in a one-entry receive buffer (UDR), which is
// popped by a bus read of UDR_ADDR.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx_en        receiver enable; low drops any frame in progress
//   sample_tick  one-clk strobe at OSR x baud rate
//   rxd          serial line (idle high), asynchronous to clk
//   cs           character size: 000=5, 001=6, 010=7, 011=8, 111=9, others=8
//   upmn         parity mode: 0x=none, 10=even, 11=odd
//   addr, read   bus address and one-clk read strobe
//   dout         received data bits [7:0] (bits at or above N read as 0)
//   rxb8n        9th data bit (0 unless 9-bit characters)
//   rxcn_flag    receive buffer full
//   fen, upen    frame / parity error of the buffered character
//   dor          data overrun (a frame was lost because the buffer was full)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter logic [7:0] UDR_ADDR = 8'hC6,
  parameter int         OSR      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic [2:0] cs,
  input  logic [1:0] upmn,
  input  logic [7:0] addr,
  input  logic       read,
  output logic [7:0] dout,
  output logic       rxb8n,
  output logic       rxcn_flag,
  output logic       fen,
  output logic       upen,
  output logic       dor
);

  localparam int            TW       = $clog2(OSR);
  localparam logic [TW-1:0] TICK_MID = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OSR - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_sync1;
  logic          r_sync2;
  logic [TW-1:0] r_tickCnt;
  logic [TW-1:0] w_nextTick;
  logic [3:0]    r_bitCnt;
  logic [3:0]    w_nextBit;
  logic [8:0]    r_data;
  logic          r_perr;
  logic          r_armed;
  logic [7:0]    r_dout;
  logic          r_rxb8;
  logic          r_rxc;
  logic          r_fe;
  logic          r_upe;
  logic          r_dor;

  logic          w_rxs;
  logic [3:0]    w_lastBit;
  logic [8:0]    w_mask;
  logic          w_parXor;
  logic          w_sampleData;
  logic          w_samplePar;
  logic          w_clearFrame;
  logic          w_commit;
  logic          w_udrRead;

  assign w_rxs     = r_sync2;
  assign w_udrRead = read && (addr == UDR_ADDR);
  assign w_mask    = 9'h1FF >> (4'd8 - w_lastBit);
  assign w_parXor  = ^(r_data & w_mask);

  assign dout      = r_dout;
  assign rxb8n     = r_rxb8;
  assign rxcn_flag = r_rxc;
  assign fen       = r_fe;
  assign upen      = r_upe;
  assign dor       = r_dor;

  // Two-flop synchroniser; resets to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Index of the last data bit for the current character size.
  always_comb begin
    w_lastBit = 4'd7;
    case (cs)
      3'b000:  w_lastBit = 4'd4;
      3'b001:  w_lastBit = 4'd5;
      3'b010:  w_lastBit = 4'd6;
      3'b111:  w_lastBit = 4'd8;
      default: w_lastBit = 4'd7;
    endcase
  end

  // Next-state logic. Counters only move on sample ticks; OSR is a power of
  // two, so the tick counter wraps to 0 by itself after each full bit.
  // The last-bit test uses >= so a mid-frame size change cannot strand the
  // bit counter past the end.
  always_comb begin
    w_nextState  = r_state;
    w_nextTick   = r_tickCnt;
    w_nextBit    = r_bitCnt;
    w_sampleData = 1'b0;
    w_samplePar  = 1'b0;
    w_clearFrame = 1'b0;
    w_commit     = 1'b0;
    if (!rx_en) begin
      w_nextState = S_IDLE;
      w_nextTick  = '0;
      w_nextBit   = '0;
    end else if (sample_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs && r_armed) begin
            w_nextState = S_START;
            w_nextTick  = '0;
          end
        end
        S_START: begin
          if (r_tickCnt == TICK_MID) begin
            w_nextTick = '0;
            if (w_rxs) begin
              w_nextState = S_IDLE;
            end else begin
              w_nextState  = S_DATA;
              w_nextBit    = '0;
              w_clearFrame = 1'b1;
            end
          end else begin
            w_nextTick = r_tickCnt + TICK_ONE;
          end
        end
        S_DATA: begin
          w_nextTick = r_tickCnt + TICK_ONE;
          if (r_tickCnt == TICK_END) begin
            w_sampleData = 1'b1;
            if (r_bitCnt >= w_lastBit) begin
              w_nextBit   = '0;
              w_nextState = upmn[1] ? S_PARITY : S_STOP;
            end else begin
              w_nextBit = r_bitCnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          w_nextTick = r_tickCnt + TICK_ONE;
          if (r_tickCnt == TICK_END) begin
            w_samplePar = 1'b1;
            w_nextState = S_STOP;
          end
        end
        S_STOP: begin
          w_nextTick = r_tickCnt + TICK_ONE;
          if (r_tickCnt == TICK_END) begin
            w_commit    = 1'b1;
            w_nextState = S_IDLE;
          end
        end
        default: begin
          w_nextState = S_IDLE;
          w_nextTick  = '0;
          w_nextBit   = '0;
        end
      endcase
    end
  end

  // Frame state: FSM, counters, shift data and parity result.
  // r_armed blocks a new start while the line stays low after a break; it is
  // re-armed as soon as the line is seen high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_tickCnt <= w_nextTick;
      r_bitCnt  <= w_nextBit;
      if (w_clearFrame) begin
        r_data <= '0;
        r_perr <= 1'b0;
      end else begin
        if (w_sampleData && (r_bitCnt <= 4'd8)) begin
          r_data[r_bitCnt] <= w_rxs;
        end
        if (w_samplePar) begin
          r_perr <= w_rxs ^ w_parXor ^ upmn[0];
        end
      end
      if (w_rxs) begin
        r_armed <= 1'b1;
      end else if (w_commit) begin
        r_armed <= 1'b0;
      end
    end
  end

  // Receive buffer and status. A commit wins over a same-cycle read, so the
  // buffer stays full with the new character and the overrun is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_rxb8 <= 1'b0;
      r_rxc  <= 1'b0;
      r_fe   <= 1'b0;
      r_upe  <= 1'b0;
      r_dor  <= 1'b0;
    end else begin
      if (w_commit && (!r_rxc || w_udrRead)) begin
        r_dout <= r_data[7:0] & w_mask[7:0];
        r_rxb8 <= r_data[8] & w_mask[8];
        r_fe   <= ~w_rxs;
        r_upe  <= r_perr;
        r_rxc  <= 1'b1;
        if (w_udrRead) begin
          r_dor <= 1'b0;
        end
      end else if (w_commit) begin
        r_dor <= 1'b1;
      end else if (w_udrRead) begin
        r_rxc <= 1'b0;
        r_dor <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed self-checking bench for uart_receiver. sample_tick fires every
// fourth clk, so one bit lasts 64 clks. Frames start aligned so that the
// receiver's mid-bit sample lands exactly 32 clks into each bit, which makes
// the commit clk of every frame known in advance.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam logic [7:0] UDR      = 8'hC6;
  localparam int         BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       sample_tick;
  logic       rxd;
  logic [2:0] cs;
  logic [1:0] upmn;
  logic [7:0] addr;
  logic       read;
  logic [7:0] dout;
  logic       rxb8n;
  logic       rxcn_flag;
  logic       fen;
  logic       upen;
  logic       dor;

  int testsRun    = 0;
  int testsFailed = 0;
  int tickPhase   = 0;

  uart_receiver #(
    .UDR_ADDR(8'hC6),
    .OSR     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .sample_tick(sample_tick),
    .rxd        (rxd),
    .cs         (cs),
    .upmn       (upmn),
    .addr       (addr),
    .read       (read),
    .dout       (dout),
    .rxb8n      (rxb8n),
    .rxcn_flag  (rxcn_flag),
    .fen        (fen),
    .upen       (upen),
    .dor        (dor)
  );

  always #5 clk = ~clk;

  // Tick strobe: tickPhase names the phase of the upcoming rising edge, and
  // only phase 0 carries a tick.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tickPhase   = (tickPhase + 1) % 4;
      sample_tick = (tickPhase == 0);
    end
  end

  // One-clk bus read; returns on the falling edge after the read took effect.
  task automatic do_read(input logic [7:0] a);
    @(negedge clk);
    read = 1'b1;
    addr = a;
    @(negedge clk);
    read = 1'b0;
    addr = 8'h00;
  endtask

  // Sends start, nbits data bits, optional parity and a stop bit. The start
  // edge is placed two clks before a tick, so the stop mid-sample edge is
  // clk 34 of the stop bit. flagBefore/flagAfter are rxcn_flag just before and
  // just after that edge; readAtCommit puts a UDR read on that same edge.
  task automatic send_frame(input logic [8:0] data, input int nbits,
                            input bit hasPar, input logic parBit,
                            input logic stopBit, input bit readAtCommit,
                            output logic flagBefore, output logic flagAfter);
    logic [11:0] fb;
    int          lastSlot;
    fb       = '1;
    fb[0]    = 1'b0;
    for (int i = 0; i < nbits; i++) fb[i+1] = data[i];
    lastSlot = nbits + 1;
    if (hasPar) begin
      fb[lastSlot] = parBit;
      lastSlot++;
    end
    fb[lastSlot] = stopBit;
    flagBefore   = 1'b0;
    flagAfter    = 1'b0;
    do @(negedge clk); while (tickPhase != 2);
    for (int s = 0; s <= lastSlot; s++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        if (k == 0) rxd = fb[s];
        if (s == lastSlot && k == 34) begin
          flagBefore = rxcn_flag;
          if (readAtCommit) begin
            read = 1'b1;
            addr = UDR;
          end
        end
        if (s == lastSlot && k == 35) begin
          flagAfter = rxcn_flag;
          read      = 1'b0;
          addr      = 8'h00;
        end
        @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  // Outputs must be zero while reset is held and stay idle once released.
  task automatic test_reset();
    rst   = 1'b1;
    rx_en = 1'b0;
    rxd   = 1'b1;
    cs    = 3'b011;
    upmn  = 2'b00;
    addr  = 8'h00;
    read  = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++; if (dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_dout: actual=%h required=00", dout); end
    testsRun++; if (rxb8n !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rxb8n: actual=%b required=0", rxb8n); end
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rxc: actual=%b required=0", rxcn_flag); end
    testsRun++; if (fen !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fen: actual=%b required=0", fen); end
    testsRun++; if (upen !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_upen: actual=%b required=0", upen); end
    testsRun++; if (dor !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dor: actual=%b required=0", dor); end
    rst   = 1'b0;
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_rxc: actual=%b required=0", rxcn_flag); end
  endtask

  // 8N1 0xA5: exact one-clk commit latency, then a wrong-address read and a
  // UDR read.
  task automatic test_8n1();
    logic fb0, fa0;
    cs   = 3'b011;
    upmn = 2'b00;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (fb0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL 8n1_rxc_before_commit: actual=%b required=0", fb0); end
    testsRun++; if (fa0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL 8n1_rxc_after_commit: actual=%b required=1", fa0); end
    testsRun++; if (dout !== 8'hA5) begin testsFailed++; $display("[TB] FAIL 8n1_dout: actual=%h required=a5", dout); end
    testsRun++; if (fen !== 1'b0) begin testsFailed++; $display("[TB] FAIL 8n1_fen: actual=%b required=0", fen); end
    testsRun++; if (upen !== 1'b0) begin testsFailed++; $display("[TB] FAIL 8n1_upen: actual=%b required=0", upen); end
    testsRun++; if (rxb8n !== 1'b0) begin testsFailed++; $display("[TB] FAIL 8n1_rxb8n: actual=%b required=0", rxb8n); end
    do_read(8'hC5);
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL 8n1_other_addr_rxc: actual=%b required=1", rxcn_flag); end
    do_read(UDR);
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL 8n1_read_rxc: actual=%b required=0", rxcn_flag); end
    testsRun++; if (dout !== 8'hA5) begin testsFailed++; $display("[TB] FAIL 8n1_read_dout_hold: actual=%h required=a5", dout); end
  endtask

  // 7E1 0x35 has four ones, so even parity requires a 0 parity bit.
  task automatic test_parity_7e1();
    logic fb0, fa0;
    cs   = 3'b010;
    upmn = 2'b10;
    send_frame(9'h035, 7, 1'b1, 1'b1, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h35) begin testsFailed++; $display("[TB] FAIL 7e1_bad_dout: actual=%h required=35", dout); end
    testsRun++; if (upen !== 1'b1) begin testsFailed++; $display("[TB] FAIL 7e1_bad_upen: actual=%b required=1", upen); end
    do_read(UDR);
    send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h35) begin testsFailed++; $display("[TB] FAIL 7e1_good_dout: actual=%h required=35", dout); end
    testsRun++; if (upen !== 1'b0) begin testsFailed++; $display("[TB] FAIL 7e1_good_upen: actual=%b required=0", upen); end
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL 7e1_good_rxc: actual=%b required=1", rxcn_flag); end
    do_read(UDR);
  endtask

  // 9O1 0x1FF: nine ones, odd parity requires a 0 parity bit. Left unread.
  task automatic test_9o1();
    logic fb0, fa0;
    cs   = 3'b111;
    upmn = 2'b11;
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'hFF) begin testsFailed++; $display("[TB] FAIL 9o1_dout: actual=%h required=ff", dout); end
    testsRun++; if (rxb8n !== 1'b1) begin testsFailed++; $display("[TB] FAIL 9o1_rxb8n: actual=%b required=1", rxb8n); end
    testsRun++; if (upen !== 1'b0) begin testsFailed++; $display("[TB] FAIL 9o1_upen: actual=%b required=0", upen); end
    testsRun++; if (fen !== 1'b0) begin testsFailed++; $display("[TB] FAIL 9o1_fen: actual=%b required=0", fen); end
  endtask

  // A 4-tick low glitch must not start a frame; buffer (still holding 0xFF)
  // must be untouched, with no overrun. A real 0x3C follows.
  task automatic test_false_start();
    logic fb0, fa0;
    cs   = 3'b011;
    upmn = 2'b00;
    do @(negedge clk); while (tickPhase != 2);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL glitch_rxc: actual=%b required=1", rxcn_flag); end
    testsRun++; if (dout !== 8'hFF) begin testsFailed++; $display("[TB] FAIL glitch_dout: actual=%h required=ff", dout); end
    testsRun++; if (dor !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch_dor: actual=%b required=0", dor); end
    do_read(UDR);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h3C) begin testsFailed++; $display("[TB] FAIL after_glitch_dout: actual=%h required=3c", dout); end
    testsRun++; if (rxb8n !== 1'b0) begin testsFailed++; $display("[TB] FAIL after_glitch_rxb8n: actual=%b required=0", rxb8n); end
    do_read(UDR);
  endtask

  // Overrun, then a read on the exact commit edge, then overrun again and a
  // plain read to clear it.
  task automatic test_back_to_back();
    logic fb0, fa0;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h11) begin testsFailed++; $display("[TB] FAIL ovr_dout: actual=%h required=11", dout); end
    testsRun++; if (dor !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_dor: actual=%b required=1", dor); end
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_rxc: actual=%b required=1", rxcn_flag); end
    send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b1, fb0, fa0);
    testsRun++; if (fa0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL rdcommit_rxc_edge: actual=%b required=1", fa0); end
    testsRun++; if (dout !== 8'h33) begin testsFailed++; $display("[TB] FAIL rdcommit_dout: actual=%h required=33", dout); end
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL rdcommit_rxc: actual=%b required=1", rxcn_flag); end
    testsRun++; if (dor !== 1'b0) begin testsFailed++; $display("[TB] FAIL rdcommit_dor: actual=%b required=0", dor); end
    send_frame(9'h044, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dor !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr2_dor: actual=%b required=1", dor); end
    testsRun++; if (dout !== 8'h33) begin testsFailed++; $display("[TB] FAIL ovr2_dout: actual=%h required=33", dout); end
    do_read(UDR);
    testsRun++; if (dor !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr2_read_dor: actual=%b required=0", dor); end
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr2_read_rxc: actual=%b required=0", rxcn_flag); end
  endtask

  // Line held low for 25 bit times: exactly one frame of zeros with a frame
  // error, no restart while the line stays low.
  task automatic test_break();
    cs   = 3'b011;
    upmn = 2'b00;
    do @(negedge clk); while (tickPhase != 2);
    rxd = 1'b0;
    repeat (25 * BIT_CLKS) @(negedge clk);
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL break_rxc: actual=%b required=1", rxcn_flag); end
    testsRun++; if (dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL break_dout: actual=%h required=00", dout); end
    testsRun++; if (fen !== 1'b1) begin testsFailed++; $display("[TB] FAIL break_fen: actual=%b required=1", fen); end
    testsRun++; if (dor !== 1'b0) begin testsFailed++; $display("[TB] FAIL break_dor: actual=%b required=0", dor); end
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    do_read(UDR);
  endtask

  // 5N1 0x1B with a low stop bit; upper data bits must read as 0.
  task automatic test_5n1_frame_error();
    logic fb0, fa0;
    cs   = 3'b000;
    upmn = 2'b00;
    send_frame(9'h01B, 5, 1'b0, 1'b0, 1'b0, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h1B) begin testsFailed++; $display("[TB] FAIL 5n1_dout: actual=%h required=1b", dout); end
    testsRun++; if (fen !== 1'b1) begin testsFailed++; $display("[TB] FAIL 5n1_fen: actual=%b required=1", fen); end
    testsRun++; if (rxcn_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL 5n1_rxc: actual=%b required=1", rxcn_flag); end
  endtask

  // Reset asserted mid-frame clears outputs at once and no commit follows;
  // the receiver then works normally.
  task automatic test_reset_mid_frame();
    logic fb0, fa0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b0;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    testsRun++; if (dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL midrst_dout: actual=%h required=00", dout); end
    testsRun++; if (fen !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_fen: actual=%b required=0", fen); end
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_rxc: actual=%b required=0", rxcn_flag); end
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    testsRun++; if (rxcn_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_no_commit: actual=%b required=0", rxcn_flag); end
    cs = 3'b011;
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, fb0, fa0);
    testsRun++; if (dout !== 8'h5A) begin testsFailed++; $display("[TB] FAIL midrst_recover_dout: actual=%h required=5a", dout); end
    testsRun++; if (fen !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_recover_fen: actual=%b required=0", fen); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_7e1();
    test_9o1();
    test_false_start();
    test_back_to_back();
    test_break();
    test_5n1_frame_error();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
